regfile_issue: RTL and testbench

REGFILE_ISSUE -- requirements
Module: regfile_issue

---
 rtl/regfile_issue_pkg.sv | 26 ++
 rtl/regfile_issue_regfile.sv | 41 ++++
 rtl/regfile_issue.sv | 104 ++++++++++
 tb/tb_regfile_issue.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_issue_pkg.sv
// Shared definitions for the regfile_issue block: opcodes, FSM states,
// instruction field positions and the default data width.
package regfile_issue_pkg;

  localparam int WIDTH_DEFAULT = 4;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Field LSBs within the 8-bit instruction; every field except imm is 2 bits wide
  localparam int OP_LSB   = 6;
  localparam int RD_LSB   = 4;
  localparam int RS1_LSB  = 2;
  localparam int RS2_LSB  = 0;
  localparam int IMM_LSB  = 0;
  localparam int IMM_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_issue_regfile.sv
// Four-entry register file: two operand read ports, one debug read port,
// one synchronous write port and an asynchronous clear.
module issue_regfile
  import regfile_issue_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       raddr_a,
  input  logic [1:0]       raddr_b,
  input  logic [1:0]       raddr_dbg,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic [WIDTH-1:0] rdata_dbg
);

  logic [WIDTH-1:0] regs_q [4];
  logic [WIDTH-1:0] regs_d [4];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a   = regs_q[raddr_a];
  assign rdata_b   = regs_q[raddr_b];
  assign rdata_dbg = regs_q[raddr_dbg];

endmodule

// File: rtl/regfile_issue.sv
// Three-cycle issue unit: latches one instruction, drives operands and op
// enables to external ALU stages, then writes the result back.
module regfile_issue
  import regfile_issue_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [WIDTH-1:0] Rd1,
  output logic [WIDTH-1:0] Rd2,
  output logic             xor_en,
  output logic             and_en,
  output logic             or_en,
  input  logic [WIDTH-1:0] alu_result,
  output logic             done,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  state_t           state_q, state_d;
  logic [7:0]       instr_q, instr_d;
  logic [WIDTH-1:0] wb_q, wb_d;

  logic [1:0]          op, rd, rs1, rs2;
  logic [IMM_BITS-1:0] imm;
  logic [WIDTH-1:0]    rdata_a, rdata_b;
  logic                we;

  assign op  = instr_q[OP_LSB  +: 2];
  assign rd  = instr_q[RD_LSB  +: 2];
  assign rs1 = instr_q[RS1_LSB +: 2];
  assign rs2 = instr_q[RS2_LSB +: 2];
  assign imm = instr_q[IMM_LSB +: IMM_BITS];

  issue_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk       (clk),
    .rstn      (rstn),
    .we        (we),
    .waddr     (rd),
    .wdata     (wb_q),
    .raddr_a   (rs1),
    .raddr_b   (rs2),
    .raddr_dbg (dbg_sel),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .rdata_dbg (dbg_data)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    wb_d        = wb_q;
    instr_ready = 1'b0;
    Rd1         = '0;
    Rd2         = '0;
    xor_en      = 1'b0;
    and_en      = 1'b0;
    or_en       = 1'b0;
    done        = 1'b0;
    we          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        Rd1    = rdata_a;
        Rd2    = rdata_b;
        xor_en = (op == OP_XOR);
        and_en = (op == OP_AND);
        or_en  = (op == OP_OR);
        // The size cast zero-extends or truncates imm to the data width
        wb_d    = (op == OP_LDI) ? WIDTH'(imm) : alu_result;
        state_d = ST_WB;
      end
      ST_WB: begin
        done    = 1'b1;
        we      = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      wb_q    <= wb_d;
    end
  end

endmodule

// File: tb/tb_regfile_issue.sv
// Self-checking bench for regfile_issue: directed scenarios plus random
// instructions checked against an architectural register model.
module tb_regfile_issue;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic [7:0]   instr;
  logic         instr_valid;
  logic         instr_ready;
  logic [W-1:0] Rd1, Rd2;
  logic         xor_en, and_en, or_en;
  logic [W-1:0] alu_result;
  logic         done;
  logic [1:0]   dbg_sel;
  logic [W-1:0] dbg_data;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] model [4];

  always #10 clk = ~clk;

  // Behavioural ALU stages: each contributes zero unless enabled
  assign alu_result = (xor_en ? (Rd1 ^ Rd2) : '0) |
                      (and_en ? (Rd1 & Rd2) : '0) |
                      (or_en  ? (Rd1 | Rd2) : '0);

  regfile_issue #(.WIDTH(W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .Rd1         (Rd1),
    .Rd2         (Rd2),
    .xor_en      (xor_en),
    .and_en      (and_en),
    .or_en       (or_en),
    .alu_result  (alu_result),
    .done        (done),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  initial begin
    #200000;
    $display("[TB] FAIL timeout got running exp finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      checks++;
      if (dbg_data !== model[i]) begin
        errors++;
        $display("[TB] FAIL %s_dbg_R%0d got %h exp %h", tag, i, dbg_data, model[i]);
      end
    end
  endtask

  // Issues one instruction from IDLE (called just after a negedge) and
  // returns just after the negedge following the writeback edge.
  task automatic do_instr(input logic [7:0] ins);
    logic [1:0]   op, rd, rs1, rs2;
    logic [W-1:0] a, b, res;
    logic [2:0]   en_exp;
    op  = ins[7:6];
    rd  = ins[5:4];
    rs1 = ins[3:2];
    rs2 = ins[1:0];
    a   = model[rs1];
    b   = model[rs2];
    case (op)
      2'b00:   begin res = W'(ins[3:0]); en_exp = 3'b000; end
      2'b01:   begin res = a ^ b;        en_exp = 3'b100; end
      2'b10:   begin res = a & b;        en_exp = 3'b010; end
      default: begin res = a | b;        en_exp = 3'b001; end
    endcase

    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_ready ins=%h got %b exp 1", ins, instr_ready);
    end
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 8'($urandom_range(0, 255));

    @(negedge clk);
    checks++;
    if ({Rd1, Rd2, xor_en, and_en, or_en, instr_ready, done} !== {a, b, en_exp, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL exec_outputs ins=%h got Rd1=%h Rd2=%h en=%b rdy=%b done=%b exp Rd1=%h Rd2=%h en=%b rdy=0 done=0",
               ins, Rd1, Rd2, {xor_en, and_en, or_en}, instr_ready, done, a, b, en_exp);
    end

    @(negedge clk);
    checks++;
    if ({Rd1, Rd2, xor_en, and_en, or_en, instr_ready, done} !== {{(2*W){1'b0}}, 3'b000, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL wb_outputs ins=%h got Rd1=%h Rd2=%h en=%b rdy=%b done=%b exp all 0 with done=1",
               ins, Rd1, Rd2, {xor_en, and_en, or_en}, instr_ready, done);
    end
    model[rd] = res;

    @(negedge clk);
    checks++;
    if ({instr_ready, done, Rd1, Rd2} !== {1'b1, 1'b0, {(2*W){1'b0}}}) begin
      errors++;
      $display("[TB] FAIL post_wb ins=%h got rdy=%b done=%b Rd1=%h Rd2=%h exp rdy=1 done=0 Rd=0",
               ins, instr_ready, done, Rd1, Rd2);
    end
    check_regs("after_instr");
  endtask

  task automatic test_reset();
    rstn        = 1'b0;
    instr       = 8'h00;
    instr_valid = 1'b0;
    dbg_sel     = 2'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({done, xor_en, and_en, or_en} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL in_reset_outputs got done/en=%b exp 0000", {done, xor_en, and_en, or_en});
    end
    rstn = 1'b1;
    #1;
    checks++;
    if ({instr_ready, done, Rd1, Rd2} !== {1'b1, 1'b0, {(2*W){1'b0}}}) begin
      errors++;
      $display("[TB] FAIL reset_release got rdy=%b done=%b Rd1=%h Rd2=%h exp rdy=1 done=0 Rd=0",
               instr_ready, done, Rd1, Rd2);
    end
    for (int i = 0; i < 4; i++) model[i] = '0;
    check_regs("reset");
  endtask

  task automatic test_ldi();
    do_instr(8'h15);
    do_instr(8'h23);
    dbg_sel = 2'd1;
    #1;
    checks++;
    if (dbg_data !== 4'd5) begin
      errors++;
      $display("[TB] FAIL ldi_R1 got %h exp 5", dbg_data);
    end
    dbg_sel = 2'd2;
    #1;
    checks++;
    if (dbg_data !== 4'd3) begin
      errors++;
      $display("[TB] FAIL ldi_R2 got %h exp 3", dbg_data);
    end
  endtask

  task automatic test_xor();
    do_instr(8'h76);
    dbg_sel = 2'd3;
    #1;
    checks++;
    if (dbg_data !== 4'd6) begin
      errors++;
      $display("[TB] FAIL xor_R3 got %h exp 6", dbg_data);
    end
  endtask

  task automatic test_and_overlap();
    do_instr(8'h96);
    dbg_sel = 2'd1;
    #1;
    checks++;
    if (dbg_data !== 4'd1) begin
      errors++;
      $display("[TB] FAIL and_R1 got %h exp 1", dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    instr       = 8'h15;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr = 8'h2A;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_exec_ready got %b exp 0", instr_ready);
    end
    @(negedge clk);
    checks++;
    if ({instr_ready, done} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL b2b_wb got rdy=%b done=%b exp rdy=0 done=1", instr_ready, done);
    end
    model[1] = 4'd5;
    @(negedge clk);
    checks++;
    if ({instr_ready, done} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL b2b_idle got rdy=%b done=%b exp rdy=1 done=0", instr_ready, done);
    end
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second_accept got rdy=%b exp 0", instr_ready);
    end
    instr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_second_done got %b exp 1", done);
    end
    model[2] = 4'hA;
    @(negedge clk);
    check_regs("b2b");
    dbg_sel = 2'd2;
    #1;
    checks++;
    if (dbg_data !== 4'hA) begin
      errors++;
      $display("[TB] FAIL b2b_R2 got %h exp a", dbg_data);
    end
  endtask

  task automatic test_reset_abort();
    instr       = 8'hC6;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({xor_en, and_en, or_en} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL abort_exec_en got %b exp 001", {xor_en, and_en, or_en});
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({or_en, done, Rd1, Rd2} !== {2'b00, {(2*W){1'b0}}}) begin
      errors++;
      $display("[TB] FAIL abort_async got or_en=%b done=%b Rd1=%h Rd2=%h exp 0", or_en, done, Rd1, Rd2);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({instr_ready, done} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL abort_after_release cycle %0d got rdy=%b done=%b exp rdy=1 done=0", c, instr_ready, done);
      end
    end
    check_regs("abort");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      do_instr(8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_xor();
    test_and_overlap();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
